// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard unit: stall FSM states and
// operand-forwarding select encodings.
package riscv_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      LD_STALL = 1'b1
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand-forwarding select for one E-stage source register.
// The M-stage result is younger than the W-stage result, so M takes priority.
module fwd_sel
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic [REG_AW-1:0] rs_e,
   output logic [1:0]        fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs_e))
         fwd = FWD_M;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e))
         fwd = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: E-stage forwarding, load-use stall FSM with
// LOAD_LAT bubbles, branch flush, and a saturating stall-cycle counter.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemReadE,
   input  logic              PCSrcE,
   input  logic              UseRs1D,
   input  logic              UseRs2D,
   input  logic [REG_AW-1:0] RD_E,
   input  logic [REG_AW-1:0] RD_M,
   input  logic [REG_AW-1:0] RD_W,
   input  logic [REG_AW-1:0] RS1_D,
   input  logic [REG_AW-1:0] RS2_D,
   input  logic [REG_AW-1:0] RS1_E,
   input  logic [REG_AW-1:0] RS2_E,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [CNT_W-1:0]  StallCount
);

   localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

   hz_state_e  state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       hit, stall, flush_d, flush_e;
   logic [1:0] fwd_a, fwd_b;

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .rd_m        (RD_M),
      .rd_w        (RD_W),
      .rs_e        (RS1_E),
      .fwd         (fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .rd_m        (RD_M),
      .rd_w        (RD_W),
      .rs_e        (RS2_E),
      .fwd         (fwd_b)
   );

   assign hit = MemReadE && (RD_E != '0) &&
                ((UseRs1D && (RD_E == RS1_D)) || (UseRs2D && (RD_E == RS2_D)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // A taken branch squashes the load's consumer, so it overrides any stall.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         state_n = RUN;
         cnt_n   = 4'd0;
      end else begin
         case (state)
            RUN: begin
               if (hit) begin
                  stall   = 1'b1;
                  flush_e = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_n = LD_STALL;
                     cnt_n   = CNT_INIT;
                  end
               end
            end
            LD_STALL: begin
               stall   = 1'b1;
               flush_e = 1'b1;
               if (cnt == 4'd0) state_n = RUN;
               else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = RUN;
         endcase
      end
   end

   assign ForwardAE = rst ? fwd_a : FWD_RF;
   assign ForwardBE = rst ? fwd_b : FWD_RF;
   assign StallF    = rst & stall;
   assign StallD    = rst & stall;
   assign FlushD    = rst & flush_d;
   assign FlushE    = rst & flush_e;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         StallCount <= '0;
      else if (StallF && (StallCount != '1))
         StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four instances cover LOAD_LAT 1/3/4 and a
// narrow counter; all share stimulus, each is checked against hand values.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, UseRs1D, UseRs2D;
   logic [4:0] RD_E, RD_M, RD_W, RS1_D, RS2_D, RS1_E, RS2_E;

   logic [1:0]  fa1, fb1, fa3, fb3, fa4, fb4, fas, fbs;
   logic        sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
   logic        sf4, sd4, fd4, fe4, sfs, sds, fds, fes;
   logic [15:0] cnt1, cnt3, cnt4;
   logic [1:0]  cnts;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReadE(MemReadE), .PCSrcE(PCSrcE), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RS1_D(RS1_D), .RS2_D(RS2_D),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .ForwardAE(fa1), .ForwardBE(fb1),
      .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1), .StallCount(cnt1));

   hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReadE(MemReadE), .PCSrcE(PCSrcE), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RS1_D(RS1_D), .RS2_D(RS2_D),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .ForwardAE(fa3), .ForwardBE(fb3),
      .StallF(sf3), .StallD(sd3), .FlushD(fd3), .FlushE(fe3), .StallCount(cnt3));

   hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReadE(MemReadE), .PCSrcE(PCSrcE), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RS1_D(RS1_D), .RS2_D(RS2_D),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .ForwardAE(fa4), .ForwardBE(fb4),
      .StallF(sf4), .StallD(sd4), .FlushD(fd4), .FlushE(fe4), .StallCount(cnt4));

   hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) us (
      .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReadE(MemReadE), .PCSrcE(PCSrcE), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RS1_D(RS1_D), .RS2_D(RS2_D),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .ForwardAE(fas), .ForwardBE(fbs),
      .StallF(sfs), .StallD(sds), .FlushD(fds), .FlushE(fes), .StallCount(cnts));

   typedef struct {
      logic       rwm, rww;
      logic [4:0] rdm, rdw, rs1e, rs2e;
      logic [1:0] exp_a, exp_b;
   } fwd_vec_t;

   typedef struct {
      logic       mr;
      logic [4:0] rde, rs1d, rs2d;
      logic       u1, u2, pc;
      logic       exp_stall, exp_fd, exp_fe;
   } hz_vec_t;

   fwd_vec_t fv[8];
   hz_vec_t  hv[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0;
      UseRs1D = 0; UseRs2D = 0;
      RD_E = 0; RD_M = 0; RD_W = 0; RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0;
   endtask

   task automatic load_hit();
      idle();
      MemReadE = 1; RD_E = 5'd7; RS2_D = 5'd7; UseRs2D = 1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      // rwm rww rdm rdw rs1e rs2e expA expB
      fv[0] = '{1, 1, 5, 5, 5, 0, 2'b10, 2'b00};
      fv[1] = '{0, 1, 5, 5, 5, 5, 2'b01, 2'b01};
      fv[2] = '{1, 0, 3, 3, 4, 3, 2'b00, 2'b10};
      fv[3] = '{1, 1, 0, 0, 0, 0, 2'b00, 2'b00};
      fv[4] = '{1, 1, 0, 6, 0, 6, 2'b00, 2'b01};
      fv[5] = '{1, 1, 8, 9, 9, 8, 2'b01, 2'b10};
      fv[6] = '{0, 0, 8, 9, 8, 9, 2'b00, 2'b00};
      fv[7] = '{1, 1, 31, 31, 31, 31, 2'b10, 2'b10};
      // mr rde rs1d rs2d u1 u2 pc  stall fd fe
      hv[0] = '{1, 7, 3, 7, 0, 1, 0, 1, 0, 1};
      hv[1] = '{1, 9, 9, 2, 1, 0, 0, 1, 0, 1};
      hv[2] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      hv[3] = '{1, 7, 7, 7, 0, 0, 0, 0, 0, 0};
      hv[4] = '{0, 7, 7, 7, 1, 1, 0, 0, 0, 0};
      hv[5] = '{1, 7, 0, 7, 0, 1, 1, 0, 1, 1};
      hv[6] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
      hv[7] = '{1, 4, 4, 5, 0, 1, 0, 0, 0, 0};

      // Outputs must be quiet under reset even with active-looking inputs.
      idle();
      load_hit();
      PCSrcE = 1; RegWriteM = 1; RD_M = 5'd7; RS1_E = 5'd7;
      #1;
      chk("rst_fwdA", fa1, 2'b00);
      chk("rst_stallF", sf1, 1'b0);
      chk("rst_flushD", fd1, 1'b0);
      chk("rst_flushE", fe1, 1'b0);
      @(negedge clk);
      chk("rst_cnt", cnt1, 16'd0);
      idle();
      rst = 1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle();
         RegWriteM = fv[i].rwm; RegWriteW = fv[i].rww;
         RD_M = fv[i].rdm; RD_W = fv[i].rdw; RS1_E = fv[i].rs1e; RS2_E = fv[i].rs2e;
         #1;
         chk($sformatf("fwdA[%0d]", i), fa1, fv[i].exp_a);
         chk($sformatf("fwdB[%0d]", i), fb1, fv[i].exp_b);
      end

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle();
         MemReadE = hv[i].mr; RD_E = hv[i].rde; RS1_D = hv[i].rs1d; RS2_D = hv[i].rs2d;
         UseRs1D = hv[i].u1; UseRs2D = hv[i].u2; PCSrcE = hv[i].pc;
         #1;
         chk($sformatf("hz_stallF[%0d]", i), sf1, hv[i].exp_stall);
         chk($sformatf("hz_stallD[%0d]", i), sd1, hv[i].exp_stall);
         chk($sformatf("hz_flushD[%0d]", i), fd1, hv[i].exp_fd);
         chk($sformatf("hz_flushE[%0d]", i), fe1, hv[i].exp_fe);
      end
      @(negedge clk);
      idle();
      #1;
      chk("hz_cnt1", cnt1, 16'd2);
      cycles(6);

      // Clear counters, then one load-use hit seen by every latency variant.
      rst = 0; #1; rst = 1;
      @(negedge clk);
      load_hit();
      #1;
      chk("ld_u1_stallF0", sf1, 1'b1);
      chk("ld_u3_stallF0", sf3, 1'b1);
      chk("ld_u3_flushE0", fe3, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         idle();
         #1;
         chk($sformatf("ld_u1_stallF%0d", i), sf1, 1'b0);
         chk($sformatf("ld_u3_stallF%0d", i), sf3, (i < 3) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk("ld_cnt1", cnt1, 16'd1);
      chk("ld_cnt3", cnt3, 16'd3);
      chk("ld_cnt4", cnt4, 16'd4);
      chk("ld_cnts", {30'd0, cnts}, 32'd1);

      // Branch in the same cycle as the hit wins; no LD_STALL entry.
      load_hit();
      PCSrcE = 1;
      #1;
      chk("br_u3_stallF", sf3, 1'b0);
      chk("br_u3_flushD", fd3, 1'b1);
      chk("br_u3_flushE", fe3, 1'b1);
      @(negedge clk);
      idle();
      #1;
      chk("br_u3_after", sf3, 1'b0);
      chk("br_u3_flushD_after", fd3, 1'b0);
      @(negedge clk);
      chk("br_cnt3", cnt3, 16'd3);

      // Five more single hits: the 2-bit counter pins at 3, the wide one keeps going.
      for (int i = 0; i < 5; i++) begin
         load_hit();
         @(negedge clk);
         idle();
         cycles(4);
      end
      chk("sat_cnts", {30'd0, cnts}, 32'd3);
      chk("sat_cnt1", cnt1, 16'd6);

      // Reset in the second bubble of a LOAD_LAT=4 stall.
      rst = 0; #1; rst = 1;
      @(negedge clk);
      load_hit();
      @(negedge clk);
      idle();
      #1;
      chk("mid_u4_stall2", sf4, 1'b1);
      rst = 0;
      #1;
      chk("mid_u4_stallF", sf4, 1'b0);
      chk("mid_u4_flushE", fe4, 1'b0);
      chk("mid_u4_cnt", cnt4, 16'd0);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_u4_stallF%0d", i), sf4, 1'b0);
      end
      chk("post_u4_cnt", cnt4, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
